dist_sweep_engine: RTL and testbench
====================================

# dist_sweep_engine

Pipelined, parametrised successor to the per-block distance formula in the stereo-distance datapath. Each accepted sample computes one candidate cost:

- cost = f2sum + g2sum + 2·wfg − wf − wg − 2·fg
- Negative results clamp to zero.

The block sweeps NDISP disparity candidates per block, tracks the minimum-cost candidate, and hands the winning index to the depth stage. It sits between the window-sum accumulators and the disparity/depth output logic.

## Interface
Parameters:
- W, 14, width of each input sum.
- NDISP, 16, candidates per sweep (≥2).
- IW, $clog2(NDISP), index width (derived, do not override).

Ports (OW = W+5):
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_first  in  1  sample is candidate 0 of a new sweep.
- wf, f2sum, g2sum, wg, wfg, fg  in  W each  unsigned window sums.
- cost_valid  out  1  per-candidate cost valid (1-cycle pulse).
- cost  out  OW  per-candidate cost, unsigned, clamped.
- cost_idx  out  IW  candidate index of cost.
- cost_sat  out  1  raw result was negative, clamped.
- best_valid  out  1  sweep result valid, held until taken.
- best_ready  in  1  consumer takes best result.
- best_cost  out  OW  minimum cost of the sweep.
- best_idx  out  IW  index of the minimum.
- sweep_err  out  1  1-cycle pulse on protocol error.

## Operation
- Accept: a sample is accepted when in_valid && in_ready.
- Stage 1 registers:
  - P = f2sum + g2sum + (wfg<<1), W+3 bits.
  - N = wf + wg + (fg<<1), W+3 bits.
  - Index counter value.
- Stage 2 computes D = P − N in OW bits, signed.
  - If D<0: cost=0, cost_sat=1.
  - Else: cost=D[OW-1:0], cost_sat=0.
  - No other overflow is possible; the max is 4·(2^W−1).
- Index counter:
  - Loaded to 0 on an accepted in_first.
  - Increments on each further accepted sample in the sweep.
  - Never wraps; the sweep ends when index NDISP−1 is accepted.
- Min tracker is updated on every cost_valid:
  - Index 0 loads unconditionally.
  - Later candidates replace the minimum only if cost < best (strict). Ties keep the lowest index.
- FSM states:
  - IDLE: in_ready=1. An accepted in_first → SWEEP. An accepted sample without in_first is discarded and pulses sweep_err.
  - SWEEP: in_ready=1. Accepting index NDISP−1 → DRAIN. An accepted in_first mid-sweep aborts the sweep: sweep_err pulses, in-flight costs of the old sweep are still emitted on cost, min tracker and index restart from that sample, state stays SWEEP.
  - DRAIN: in_ready=0. Waits for the last cost to leave stage 2, then asserts best_valid → HOLD.
  - HOLD: in_ready=0. best_valid/best_cost/best_idx are stable. On best_ready → IDLE.
- Reset (rst_n=0 at a clock edge) applies at any point, including mid-sweep or HOLD:
  - State goes to IDLE and the pipeline is flushed.
  - Outputs: in_ready=0 during reset, 1 in the first cycle after release.
  - cost_valid=0, cost=0, cost_idx=0, cost_sat=0.
  - best_valid=0, best_cost=0, best_idx=0, sweep_err=0.
  - No cost_valid pulse emerges for samples accepted before reset.

## Timing
- All outputs are registered.
- Sample accepted at edge t:
  - cost_valid/cost/cost_idx/cost_sat valid in the cycle after edge t+2 (latency 2).
  - Throughput is 1 sample/cycle within a sweep.
- Last candidate accepted at edge t:
  - in_ready=0 from edge t+1.
  - best_valid rises at edge t+3, coincident with the clock after that candidate's cost pulse.
- Handshake completes at edge h (best_valid && best_ready):
  - best_valid falls at edge h+1.
  - in_ready rises at edge h+1.
  - The next in_first is accepted no earlier than edge h+1.
- Minimum sweep period: NDISP+3 cycles plus HOLD wait.
- sweep_err pulses at edge t+1 for an offending sample accepted at edge t.

## Test plan
- Single sample, W=14: wf=100, f2sum=5000, g2sum=4000, wg=200, wfg=300, fg=1000 → cost=7300, cost_sat=0, 2 cycles after accept.
- Extremes: f2sum=g2sum=wfg=16383, rest 0 → cost=65532. Then wf=16383, rest 0 → cost=0, cost_sat=1.
- Full sweep, NDISP=16, costs 90,80,…; idx 5 and idx 9 both =10, rest larger → best_idx=5, best_cost=10. in_ready low from the edge after idx 15 until handshake. best_valid held 4 cycles with best_ready=0.
- Abort: in_first at idx 7 → sweep_err pulse. The new sweep's best reflects only post-abort samples, indices 0–15 counted from the restart.
- Samples without in_first in IDLE → discarded, sweep_err pulse each, no cost_valid.
- rst_n=0 for one cycle mid-sweep and again during HOLD → all outputs at reset values, no stray cost_valid. A new sweep after release works normally.

Source files
------------

// File: rtl/dist_sweep_engine.sv
// dist_sweep_engine: pipelined stereo window-distance cost with a disparity sweep.
// Each accepted sample yields cost = f2sum + g2sum + 2*wfg - wf - wg - 2*fg,
// clamped at zero; the lowest-cost candidate of each sweep (ties keep the
// lowest index) is offered to the depth stage through a valid/ready hold.
//
// State  | Meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for candidate 0; stray samples are dropped, flagged
// SWEEP  | accepting candidates 1..NDISP-1; a new in_first restarts
// DRAIN  | input closed, waiting for the last cost to leave the pipe
// HOLD   | best result presented until the consumer takes it

module dist_sweep_engine #(
    parameter int W     = 14,
    parameter int NDISP = 16,
    parameter int IW    = $clog2(NDISP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic [W-1:0]      wf,
    input  logic [W-1:0]      f2sum,
    input  logic [W-1:0]      g2sum,
    input  logic [W-1:0]      wg,
    input  logic [W-1:0]      wfg,
    input  logic [W-1:0]      fg,
    output logic              cost_valid,
    output logic [W+4:0]      cost,
    output logic [IW-1:0]     cost_idx,
    output logic              cost_sat,
    output logic              best_valid,
    input  logic              best_ready,
    output logic [W+4:0]      best_cost,
    output logic [IW-1:0]     best_idx,
    output logic              sweep_err
);

    localparam int OW = W + 5;
    localparam int PW = W + 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            s1_valid_q, s1_valid_d;
    logic [PW-1:0]   s1_p_q, s1_n_q;
    logic [IW-1:0]   s1_idx_q;
    logic            cost_valid_q;
    logic [OW-1:0]   cost_q;
    logic [IW-1:0]   cost_idx_q;
    logic            cost_sat_q;
    logic            best_valid_q, best_valid_d;
    logic [OW-1:0]   best_cost_q;
    logic [IW-1:0]   best_idx_q;
    logic            sweep_err_q, sweep_err_d;

    logic            accept;
    logic [PW-1:0]   p_d, n_d;
    logic [OW-1:0]   diff;

    assign accept = in_valid && in_ready_q;

    // Positive and negative halves are summed separately so stage 2 is a single subtract.
    assign p_d  = {3'b000, f2sum} + {3'b000, g2sum} + {2'b00, wfg, 1'b0};
    assign n_d  = {3'b000, wf} + {3'b000, wg} + {2'b00, fg, 1'b0};
    assign diff = {2'b00, s1_p_q} - {2'b00, s1_n_q};

    // Next-state and handshake decode; in_ready is registered from the next state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        s1_valid_d   = 1'b0;
        sweep_err_d  = 1'b0;
        best_valid_d = best_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_first) begin
                        state_d    = ST_SWEEP;
                        s1_valid_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        sweep_err_d = 1'b1;
                    end
                end
            end
            ST_SWEEP: begin
                if (accept) begin
                    s1_valid_d = 1'b1;
                    if (in_first) begin
                        sweep_err_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == IW'(NDISP - 2)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // Last cost is on the output this cycle and the tracker absorbs it at this edge.
                if (cost_valid_q && !s1_valid_q) begin
                    state_d      = ST_HOLD;
                    best_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (best_ready) begin
                    state_d      = ST_IDLE;
                    best_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                best_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_SWEEP);
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            cnt_q        <= '0;
            best_valid_q <= 1'b0;
            sweep_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
            best_valid_q <= best_valid_d;
            sweep_err_q  <= sweep_err_d;
        end
    end

    // Two-stage cost pipeline: operand sums, then subtract with clamp at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_p_q       <= '0;
            s1_n_q       <= '0;
            s1_idx_q     <= '0;
            cost_valid_q <= 1'b0;
            cost_q       <= '0;
            cost_idx_q   <= '0;
            cost_sat_q   <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            if (s1_valid_d) begin
                s1_p_q   <= p_d;
                s1_n_q   <= n_d;
                s1_idx_q <= cnt_d;
            end
            cost_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                cost_q     <= diff[OW-1] ? '0 : diff;
                cost_sat_q <= diff[OW-1];
                cost_idx_q <= s1_idx_q;
            end
        end
    end

    // Minimum tracker: index 0 reloads, later candidates win only when strictly lower.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_cost_q <= '0;
            best_idx_q  <= '0;
        end else if (cost_valid_q && ((cost_idx_q == '0) || (cost_q < best_cost_q))) begin
            best_cost_q <= cost_q;
            best_idx_q  <= cost_idx_q;
        end
    end

    assign in_ready   = in_ready_q;
    assign cost_valid = cost_valid_q;
    assign cost       = cost_q;
    assign cost_idx   = cost_idx_q;
    assign cost_sat   = cost_sat_q;
    assign best_valid = best_valid_q;
    assign best_cost  = best_cost_q;
    assign best_idx   = best_idx_q;
    assign sweep_err  = sweep_err_q;

endmodule

// File: tb/tb_dist_sweep_engine.sv
// Bench for dist_sweep_engine: directed and random sweeps checked against an
// arithmetic cost/minimum model with a timed scoreboard for per-candidate costs.

module tb_dist_sweep_engine;

    localparam int W     = 14;
    localparam int NDISP = 16;
    localparam int IW    = $clog2(NDISP);
    localparam int OW    = W + 5;
    localparam int MAXV  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic          best_ready = 1'b0;
    logic [W-1:0]  wf = '0, f2sum = '0, g2sum = '0, wg = '0, wfg = '0, fg = '0;
    logic          in_ready, cost_valid, cost_sat, best_valid, sweep_err;
    logic [OW-1:0] cost, best_cost;
    logic [IW-1:0] cost_idx, best_idx;

    always #5 clk = ~clk;

    dist_sweep_engine #(.W(W), .NDISP(NDISP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .wf         (wf),
        .f2sum      (f2sum),
        .g2sum      (g2sum),
        .wg         (wg),
        .wfg        (wfg),
        .fg         (fg),
        .cost_valid (cost_valid),
        .cost       (cost),
        .cost_idx   (cost_idx),
        .cost_sat   (cost_sat),
        .best_valid (best_valid),
        .best_ready (best_ready),
        .best_cost  (best_cost),
        .best_idx   (best_idx),
        .sweep_err  (sweep_err)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cost;
        int sat;
        int idx;
        int due;
    } exp_t;

    exp_t cq[$];
    int   eq[$];
    exp_t mon_e;

    int a_wf[NDISP], a_f2[NDISP], a_g2[NDISP], a_wg[NDISP], a_wfg[NDISP], a_fg[NDISP];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model(input int wf_v, f2_v, g2_v, wg_v, wfg_v, fg_v,
                                  output int c, output int s);
        int r;
        r = f2_v + g2_v + 2 * wfg_v - wf_v - wg_v - 2 * fg_v;
        s = (r < 0) ? 1 : 0;
        c = (r < 0) ? 0 : r;
    endfunction

    function automatic void best_model(output int bc, output int bi);
        int c, s;
        model(a_wf[0], a_f2[0], a_g2[0], a_wg[0], a_wfg[0], a_fg[0], bc, s);
        bi = 0;
        for (int i = 1; i < NDISP; i++) begin
            model(a_wf[i], a_f2[i], a_g2[i], a_wg[i], a_wfg[i], a_fg[i], c, s);
            if (c < bc) begin
                bc = c;
                bi = i;
            end
        end
    endfunction

    // Scoreboard: each cost/err pulse must match the oldest expectation on its due cycle.
    always @(negedge clk) begin
        while (cq.size() > 0 && cq[0].due < cyc) begin
            check_eq("cost_missing", cyc, cq[0].due);
            void'(cq.pop_front());
        end
        while (eq.size() > 0 && eq[0] < cyc) begin
            check_eq("err_missing", cyc, eq[0]);
            void'(eq.pop_front());
        end
        if (cost_valid) begin
            if (cq.size() == 0) begin
                check_eq("cost_unexpected", cost_valid, 0);
            end else begin
                mon_e = cq.pop_front();
                check_eq("cost_time", cyc, mon_e.due);
                check_eq("cost", cost, mon_e.cost);
                check_eq("cost_sat", cost_sat, mon_e.sat);
                check_eq("cost_idx", cost_idx, mon_e.idx);
            end
        end
        if (sweep_err) begin
            if (eq.size() == 0) begin
                check_eq("err_unexpected", sweep_err, 0);
            end else begin
                check_eq("err_time", cyc, eq[0]);
                void'(eq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit first, input int wf_v, f2_v, g2_v, wg_v, wfg_v, fg_v,
                       input bit pipe, input bit err, input int idx);
        exp_t e;
        int c, s;
        in_valid = 1'b1;
        in_first = first;
        wf    = W'(wf_v);
        f2sum = W'(f2_v);
        g2sum = W'(g2_v);
        wg    = W'(wg_v);
        wfg   = W'(wfg_v);
        fg    = W'(fg_v);
        if (pipe) begin
            model(wf_v, f2_v, g2_v, wg_v, wfg_v, fg_v, c, s);
            e.cost = c;
            e.sat  = s;
            e.idx  = idx;
            e.due  = cyc + 2;
            cq.push_back(e);
        end
        if (err) eq.push_back(cyc + 1);
        step();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NDISP; i++) begin
            a_wf[i]  = $urandom_range(0, MAXV);
            a_f2[i]  = $urandom_range(0, MAXV);
            a_g2[i]  = $urandom_range(0, MAXV);
            a_wg[i]  = $urandom_range(0, MAXV);
            a_wfg[i] = $urandom_range(0, MAXV);
            a_fg[i]  = $urandom_range(0, MAXV);
        end
    endtask

    task automatic set_cost(input int i, input int c);
        a_wf[i] = 0; a_f2[i] = c; a_g2[i] = 0; a_wg[i] = 0; a_wfg[i] = 0; a_fg[i] = 0;
    endtask

    task automatic feed(input int n, input bit err_first);
        for (int i = 0; i < n; i++) begin
            put(i == 0, a_wf[i], a_f2[i], a_g2[i], a_wg[i], a_wfg[i], a_fg[i],
                1'b1, (i == 0) && err_first, i);
        end
    endtask

    task automatic finish_sweep(input int hold, input bit handshake);
        int bc, bi;
        best_model(bc, bi);
        check_eq("ready_low_after_last", in_ready, 0);
        step();
        check_eq("best_valid_early", best_valid, 0);
        check_eq("ready_drain", in_ready, 0);
        step();
        check_eq("best_valid_rise", best_valid, 1);
        check_eq("best_cost", best_cost, bc);
        check_eq("best_idx", best_idx, bi);
        if (handshake) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                in_first = 1'b1;
                wf = W'($urandom); f2sum = W'($urandom); g2sum = W'($urandom);
                step();
                check_eq("hold_valid", best_valid, 1);
                check_eq("hold_cost", best_cost, bc);
                check_eq("hold_idx", best_idx, bi);
                check_eq("hold_ready", in_ready, 0);
            end
            in_valid   = 1'b0;
            in_first   = 1'b0;
            best_ready = 1'b1;
            step();
            best_ready = 1'b0;
            check_eq("best_valid_fall", best_valid, 0);
            check_eq("ready_after_take", in_ready, 1);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_cost_valid", cost_valid, 0);
        check_eq("rst_cost", cost, 0);
        check_eq("rst_cost_idx", cost_idx, 0);
        check_eq("rst_cost_sat", cost_sat, 0);
        check_eq("rst_best_valid", best_valid, 0);
        check_eq("rst_best_cost", best_cost, 0);
        check_eq("rst_best_idx", best_idx, 0);
        check_eq("rst_sweep_err", sweep_err, 0);
    endtask

    task automatic reset_pulse();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step();
        cq.delete();
        eq.delete();
        check_reset_outputs();
        rst_n = 1'b1;
        step();
        check_eq("ready_after_release", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        check_reset_outputs();
        rst_n = 1'b1;
        step();
        check_eq("ready_after_release", in_ready, 1);

        // Directed vectors: nominal, largest positive, negative clamp.
        fill_random();
        a_wf[0] = 100;  a_f2[0] = 5000; a_g2[0] = 4000; a_wg[0] = 200; a_wfg[0] = 300; a_fg[0] = 1000;
        a_wf[1] = 0;    a_f2[1] = MAXV; a_g2[1] = MAXV; a_wg[1] = 0;   a_wfg[1] = MAXV; a_fg[1] = 0;
        a_wf[2] = MAXV; a_f2[2] = 0;    a_g2[2] = 0;    a_wg[2] = 0;   a_wfg[2] = 0;    a_fg[2] = 0;
        feed(NDISP, 1'b0);
        finish_sweep(2, 1'b1);

        // Equal minima at 5 and 9: the earlier index must win.
        for (int i = 0; i < NDISP; i++) set_cost(i, 100 + i);
        set_cost(0, 90); set_cost(1, 80); set_cost(2, 70); set_cost(3, 60); set_cost(4, 50);
        set_cost(5, 10); set_cost(6, 40); set_cost(7, 30); set_cost(8, 20); set_cost(9, 10);
        feed(NDISP, 1'b0);
        finish_sweep(4, 1'b1);
        check_eq("tie_best_idx_directed", best_idx, 5);

        for (int k = 0; k < 5; k++) begin
            fill_random();
            feed(NDISP, 1'b0);
            finish_sweep($urandom_range(0, 3), 1'b1);
        end

        // Stray samples in IDLE are dropped with an error pulse each.
        for (int k = 0; k < 3; k++) begin
            put(1'b0, $urandom_range(0, MAXV), $urandom_range(0, MAXV), 0, 0, 0, 0, 1'b0, 1'b1, 0);
        end
        check_eq("idle_ready", in_ready, 1);
        step();
        step();

        // Abort at the eighth sample; the old in-flight costs still drain out.
        fill_random();
        feed(7, 1'b0);
        fill_random();
        feed(NDISP, 1'b1);
        finish_sweep(1, 1'b1);

        // Reset in the middle of a sweep, then a clean sweep.
        fill_random();
        feed(5, 1'b0);
        reset_pulse();
        step();
        fill_random();
        feed(NDISP, 1'b0);
        finish_sweep(0, 1'b1);

        // Reset while holding a result, then a clean sweep.
        fill_random();
        feed(NDISP, 1'b0);
        finish_sweep(0, 1'b0);
        step();
        check_eq("hold_before_reset", best_valid, 1);
        reset_pulse();
        fill_random();
        feed(NDISP, 1'b0);
        finish_sweep(2, 1'b1);

        repeat (4) step();
        check_eq("cost_queue_empty", cq.size(), 0);
        check_eq("err_queue_empty", eq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
